// File: rtl/fp_pkg.sv
// Shared constants and state encoding for the shared FP multiplier arbiter.
package fp_pkg;

    localparam int unsigned FP_W = 32;

    localparam logic [FP_W-1:0] FP_ONE  = 32'h3F80_0000;
    localparam logic [FP_W-1:0] FP_ZERO = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/fp_mul.sv
// Combinational IEEE-754 single multiply, round-to-nearest-even.
// Denormal inputs flush to zero; tiny results flush to zero; overflow gives infinity.
module fp_mul
    import fp_pkg::*;
(
    input  logic [FP_W-1:0] a,
    input  logic [FP_W-1:0] b,
    output logic [FP_W-1:0] p
);

    logic        sign;
    logic [7:0]  ea;
    logic [7:0]  eb;
    logic [47:0] prod;
    logic [47:0] norm;
    logic        round_up;
    logic [24:0] rounded;
    logic [9:0]  esum;
    logic [22:0] frac;
    logic        a_nan;
    logic        b_nan;

    // Significand product, normalise, round, then special-case overrides.
    always_comb begin
        ea       = a[30:23];
        eb       = b[30:23];
        sign     = a[31] ^ b[31];
        a_nan    = (ea == 8'hFF) && (a[22:0] != 23'd0);
        b_nan    = (eb == 8'hFF) && (b[22:0] != 23'd0);
        prod     = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        norm     = prod[47] ? prod : {prod[46:0], 1'b0};
        round_up = norm[23] & ((|norm[22:0]) | norm[24]);
        rounded  = {1'b0, norm[47:24]} + 25'(round_up);
        frac     = rounded[24] ? rounded[23:1] : rounded[22:0];
        esum     = 10'(ea) + 10'(eb) + 10'(prod[47]) + 10'(rounded[24]);

        p = {sign, 8'(esum - 10'd127), frac};
        if (esum >= 10'd382) begin
            p = {sign, 8'hFF, 23'd0};
        end else if (esum <= 10'd127) begin
            p = {sign, 31'd0};
        end
        if (ea == 8'd0 || eb == 8'd0) begin
            p = {sign, 31'd0};
        end
        if (ea == 8'hFF || eb == 8'hFF) begin
            if (a_nan || b_nan || ea == 8'd0 || eb == 8'd0) begin
                p = 32'h7FC0_0000;
            end else begin
                p = {sign, 8'hFF, 23'd0};
            end
        end
    end

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after 'last', wrapping.
module rr_pick #(
    parameter int unsigned NREQ = 2,
    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] gnt_onehot,
    output logic [IW-1:0]   gnt_idx
);

    logic [IW-1:0] idx;
    logic          found;

    // Scan last+1, last+2, ... (mod NREQ); the previous winner is checked last.
    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        found      = 1'b0;
        idx        = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = IW'((32'(last) + k) % NREQ);
            if (!found && req[idx]) begin
                found           = 1'b1;
                gnt_idx         = idx;
                gnt_onehot[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Round-robin sharing of one multicycle-path FP multiplier among NREQ requesters.
module fp_mul_arbiter
    import fp_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned LAT  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [FP_W*NREQ-1:0] req_a,
    input  logic [FP_W*NREQ-1:0] req_b,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [FP_W-1:0]      rsp_data,
    output logic                 busy
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = $clog2(LAT) + 1;

    state_e          state_q,    state_d;
    logic [FP_W-1:0] op_a_q,     op_a_d;
    logic [FP_W-1:0] op_b_q,     op_b_d;
    logic [IW-1:0]   gnt_id_q,   gnt_id_d;
    logic [IW-1:0]   last_gnt_q, last_gnt_d;
    logic [CW-1:0]   cnt_q,      cnt_d;
    logic [FP_W-1:0] rsp_data_q, rsp_data_d;

    logic [FP_W-1:0] a_lane [NREQ];
    logic [FP_W-1:0] b_lane [NREQ];
    logic [NREQ-1:0] pick_onehot;
    logic [IW-1:0]   pick_idx;
    logic [FP_W-1:0] prod;

    // Unpack per-requester operand lanes.
    for (genvar g = 0; g < int'(NREQ); g++) begin : g_lane
        assign a_lane[g] = req_a[g*FP_W +: FP_W];
        assign b_lane[g] = req_b[g*FP_W +: FP_W];
    end

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req        (req_valid),
        .last       (last_gnt_q),
        .gnt_onehot (pick_onehot),
        .gnt_idx    (pick_idx)
    );

    fp_mul u_mul (
        .a (op_a_q),
        .b (op_b_q),
        .p (prod)
    );

    // Next-state: accept in IDLE, hold operands LAT cycles, present until accepted.
    always_comb begin
        state_d    = state_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        gnt_id_d   = gnt_id_q;
        last_gnt_d = last_gnt_q;
        cnt_d      = cnt_q;
        rsp_data_d = rsp_data_q;
        case (state_q)
            S_IDLE: begin
                if (|pick_onehot) begin
                    op_a_d   = a_lane[pick_idx];
                    op_b_d   = b_lane[pick_idx];
                    gnt_id_d = pick_idx;
                    cnt_d    = CW'(LAT - 1);
                    state_d  = S_HOLD;
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    rsp_data_d = prod;
                    state_d    = S_RESP;
                end else begin
                    cnt_d = CW'(cnt_q - 1'b1);
                end
            end
            S_RESP: begin
                if (rsp_ready[gnt_id_q]) begin
                    last_gnt_d = gnt_id_q;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset drops any in-flight operation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            op_a_q     <= '0;
            op_b_q     <= '0;
            gnt_id_q   <= '0;
            last_gnt_q <= IW'(NREQ - 1);
            cnt_q      <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            gnt_id_q   <= gnt_id_d;
            last_gnt_q <= last_gnt_d;
            cnt_q      <= cnt_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    // Handshake outputs decoded from state; ready forced low while reset is held.
    assign req_ready = (state_q == S_IDLE && !reset) ? pick_onehot : '0;
    assign rsp_valid = (state_q == S_RESP) ? (NREQ'(1) << gnt_id_q) : '0;
    assign rsp_data  = rsp_data_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Randomised and directed bench for fp_mul_arbiter with a cycle-level reference model.
module tb_fp_mul_arbiter;

    localparam int unsigned NREQ = 2;
    localparam int unsigned LAT  = 2;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  rv    = 2'b00;
    logic [1:0]  rr    = 2'b00;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_data;
    logic        busy;
    logic [31:0] a_arr [2];
    logic [31:0] b_arr [2];
    logic [63:0] ra, rb;

    logic [2:0]  v1  = 3'b000;
    logic [2:0]  rr1 = 3'b000;
    logic [95:0] a1  = '0;
    logic [95:0] b1  = '0;
    logic [2:0]  rdy1, val1;
    logic [31:0] dat1;
    logic        busy1;

    assign ra = {a_arr[1], a_arr[0]};
    assign rb = {b_arr[1], b_arr[0]};

    always #5 clk = ~clk;

    fp_mul_arbiter #(.NREQ(NREQ), .LAT(LAT)) u0 (
        .clk(clk), .reset(reset), .req_valid(rv), .req_ready(req_ready),
        .req_a(ra), .req_b(rb), .rsp_valid(rsp_valid), .rsp_ready(rr),
        .rsp_data(rsp_data), .busy(busy)
    );

    fp_mul_arbiter #(.NREQ(3), .LAT(1)) u1 (
        .clk(clk), .reset(reset), .req_valid(v1), .req_ready(rdy1),
        .req_a(a1), .req_b(b1), .rsp_valid(val1), .rsp_ready(rr1),
        .rsp_data(dat1), .busy(busy1)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Stimulus queues, scoreboard and transaction logs.
    logic [63:0] op_q  [2][$];
    logic [31:0] exp_q [2][$];
    int          g_id[$], g_cyc[$], r_id[$], r_cyc[$];
    logic [31:0] r_data[$];
    logic [1:0]  hs_q    = 2'b00;
    int          rr_mode = 0;   // 0: always ready, 1: rr_mask, 2: random
    logic [1:0]  rr_mask = 2'b00;

    // Reference model state
    int m_owner = -1;
    int m_last  = NREQ - 1;
    int m_age   = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
        n_chk++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, got, expv, cyc);
        end
    endtask

    // IEEE single <-> host real conversion; products are formed by the simulator's real multiply.
    function automatic real sp2r(input logic [31:0] x);
        if (x[30:23] == 8'd0) return $bitstoreal({x[31], 63'd0});
        return $bitstoreal({x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] r2sp(input real r);
        logic [63:0] d;
        d = $realtobits(r);
        if (d[62:52] == 11'd0) return {d[63], 31'd0};
        return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction

    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        return r2sp(sp2r(a) * sp2r(b));
    endfunction

    // Random operand whose significand product stays exact (12-bit significands).
    function automatic logic [31:0] rand_fp();
        logic [31:0] x;
        if ($urandom_range(0, 7) == 0) x = {1'($urandom_range(0, 1)), 31'd0};
        else x = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)),
                  11'($urandom_range(0, 2047)), 12'd0};
        return x;
    endfunction

    task automatic push(input int i, input logic [31:0] a, input logic [31:0] b);
        op_q[i].push_back({a, b});
        exp_q[i].push_back(ref_mul(a, b));
    endtask

    task automatic clear_logs();
        g_id.delete(); g_cyc.delete(); r_id.delete(); r_cyc.delete(); r_data.delete();
    endtask

    task automatic wait_rsp(input int n, input string nm, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk); #1;
            if (r_id.size() >= n) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            n_chk++; n_fail++;
            $display("FAIL %s: timed out with %0d responses, %0d required", nm, r_id.size(), n);
        end
    endtask

    always @(posedge clk) cyc++;

    // Requester drivers: hold valid and operands until accepted; pick rsp_ready by mode.
    initial forever begin
        @(posedge clk); #2;
        for (int i = 0; i < 2; i++) begin
            if (hs_q[i]) begin
                if (op_q[i].size() > 0) void'(op_q[i].pop_front());
                rv[i] = 1'b0;
            end
            if (!rv[i] && op_q[i].size() > 0 && (rr_mode != 2 || $urandom_range(0, 3) != 0)) begin
                rv[i]    = 1'b1;
                a_arr[i] = op_q[i][0][63:32];
                b_arr[i] = op_q[i][0][31:0];
            end
        end
        case (rr_mode)
            0:       rr = 2'b11;
            1:       rr = rr_mask;
            default: rr = 2'($urandom_range(0, 3));
        endcase
    end

    // Compare process: predict outputs for this cycle, check, then advance the model.
    always @(negedge clk) begin
        int win;
        int jj;
        logic [1:0] e_rdy;
        logic [1:0] e_val;
        hs_q = reset ? 2'b00 : (rv & req_ready);
        for (int i = 0; i < 2; i++) begin
            if (hs_q[i]) begin g_id.push_back(i); g_cyc.push_back(cyc); end
        end
        if (reset) begin
            chk("rst_req_ready", 32'(req_ready), 32'd0);
            chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_rsp_data", rsp_data, 32'd0);
            if (m_owner >= 0 && exp_q[m_owner].size() > 0) void'(exp_q[m_owner].pop_front());
            m_owner = -1;
            m_last  = NREQ - 1;
            m_age   = 0;
        end else begin
            win = -1;
            if (m_owner < 0) begin
                for (int k = 1; k <= NREQ; k++) begin
                    jj = (m_last + k) % NREQ;
                    if (win < 0 && rv[jj]) win = jj;
                end
            end
            e_rdy = (win >= 0) ? 2'(1 << win) : 2'b00;
            e_val = (m_owner >= 0 && m_age > LAT) ? 2'(1 << m_owner) : 2'b00;
            chk("req_ready", 32'(req_ready), 32'(e_rdy));
            chk("rsp_valid", 32'(rsp_valid), 32'(e_val));
            chk("busy", 32'(busy), 32'(m_owner >= 0));
            if (e_val != 2'b00 && exp_q[m_owner].size() > 0)
                chk("rsp_data", rsp_data, exp_q[m_owner][0]);
            for (int i = 0; i < 2; i++) begin
                if (rsp_valid[i] && rr[i]) begin
                    r_id.push_back(i); r_cyc.push_back(cyc); r_data.push_back(rsp_data);
                    if (exp_q[i].size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL unexpected_rsp: requester %0d got %h, expected no response", i, rsp_data);
                    end else begin
                        void'(exp_q[i].pop_front());
                    end
                end
            end
            if (win >= 0) begin
                m_owner = win;
                m_age   = 1;
            end else if (e_val != 2'b00 && rr[m_owner]) begin
                m_last  = m_owner;
                m_owner = -1;
            end else if (m_owner >= 0) begin
                m_age++;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // One LAT=1 transaction on the three-requester instance.
    task automatic u1_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic [31:0] expv);
        @(posedge clk); #1;
        v1 = 3'(1 << i); a1 = {3{a}}; b1 = {3{b}}; rr1 = 3'b111;
        #1 chk("u1_ready", 32'(rdy1), 32'(1 << i));
        @(posedge clk); #1 v1 = 3'b000;
        chk("u1_hold_busy", 32'(busy1), 32'd1);
        chk("u1_hold_valid", 32'(val1), 32'd0);
        @(posedge clk); #1;
        chk("u1_rsp_valid", 32'(val1), 32'(1 << i));
        chk("u1_rsp_data", dat1, expv);
        @(posedge clk); #1;
        chk("u1_done_valid", 32'(val1), 32'd0);
        chk("u1_done_busy", 32'(busy1), 32'd0);
    endtask

    initial begin
        bit   ok;
        logic [31:0] held;
        int   base;
        a_arr[0] = '0; a_arr[1] = '0; b_arr[0] = '0; b_arr[1] = '0;

        chk("model_1p5x2", ref_mul(32'h3FC0_0000, 32'h4000_0000), 32'h4040_0000);
        chk("model_neg", ref_mul(32'hBFC0_0000, 32'hC020_0000), 32'h4070_0000);
        chk("model_zero", ref_mul(32'h0000_0000, 32'h40A0_0000), 32'h0000_0000);

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Single request: latency and value
        clear_logs();
        push(0, 32'h3FC0_0000, 32'h4000_0000);
        wait_rsp(1, "t1_timeout", ok);
        if (ok) begin
            chk("t1_data", r_data[0], 32'h4040_0000);
            chk("t1_latency", 32'(r_cyc[0] - g_cyc[0]), 32'd3);
        end

        // Simultaneous requests after reset: 0 first
        do_reset();
        clear_logs();
        push(0, 32'h3F80_0000, 32'h3F80_0000);
        push(1, 32'hBFC0_0000, 32'hC020_0000);
        wait_rsp(2, "t2_timeout", ok);
        if (ok) begin
            chk("t2_first_id", 32'(r_id[0]), 32'd0);
            chk("t2_first_data", r_data[0], 32'h3F80_0000);
            chk("t2_second_id", 32'(r_id[1]), 32'd1);
            chk("t2_second_data", r_data[1], 32'h4070_0000);
        end

        // Continuous contention: alternating grants
        clear_logs();
        for (int n = 0; n < 3; n++) begin
            push(0, 32'h4040_0000, 32'h3F00_0000);
            push(1, 32'h4040_0000, 32'h3F00_0000);
        end
        wait_rsp(6, "t3_timeout", ok);
        if (ok) begin
            for (int n = 0; n < 6; n++) begin
                chk("t3_grant_order", 32'(g_id[n]), 32'(n % 2));
                chk("t3_data", r_data[n], 32'h3FC0_0000);
            end
        end

        // Backpressure on requester 0 while requester 1 waits
        clear_logs();
        rr_mode = 1; rr_mask = 2'b00;
        push(0, 32'h3F80_0000, 32'h4040_0000);
        ok = 1'b0;
        for (int t = 0; t < 20 && !ok; t++) begin @(negedge clk); ok = rsp_valid[0]; end
        chk("t4_valid_seen", 32'(ok), 32'd1);
        held = rsp_data;
        @(posedge clk); #1 push(1, 32'h4000_0000, 32'h4000_0000);
        repeat (5) begin
            @(negedge clk);
            chk("t4_valid_hold", 32'(rsp_valid), 32'd1);
            chk("t4_data_hold", rsp_data, held);
            chk("t4_ready1_low", 32'(req_ready[1]), 32'd0);
        end
        @(posedge clk); #1 rr_mask = 2'b01;
        ok = 1'b0;
        for (int t = 0; t < 20 && !ok; t++) begin @(negedge clk); #1; ok = (g_id.size() > 1); end
        chk("t4_req1_granted", 32'(ok), 32'd1);
        if (ok && r_cyc.size() > 0) chk("t4_req1_issue_cycle", 32'(g_cyc[1]), 32'(r_cyc[0] + 1));
        rr_mode = 0;
        wait_rsp(2, "t4_timeout", ok);
        if (ok) chk("t4_req1_data", r_data[1], 32'h4080_0000);

        // Reset pulse during HOLD drops the operation
        clear_logs();
        push(0, 32'hBF80_0000, 32'h3F80_0000);
        ok = 1'b0;
        for (int t = 0; t < 20 && !ok; t++) begin @(negedge clk); #1; ok = (g_id.size() > 0); end
        chk("t5_granted", 32'(ok), 32'd1);
        @(posedge clk); #1 reset = 1'b1;
        #1;
        chk("t5_async_ready", 32'(req_ready), 32'd0);
        chk("t5_async_valid", 32'(rsp_valid), 32'd0);
        chk("t5_async_busy", 32'(busy), 32'd0);
        chk("t5_async_data", rsp_data, 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        repeat (8) @(posedge clk);
        chk("t5_no_response", 32'(r_id.size()), 32'd0);
        push(0, 32'hBF80_0000, 32'h3F80_0000);
        wait_rsp(1, "t5_timeout", ok);
        if (ok) chk("t5_reissue_data", r_data[0], 32'hBF80_0000);

        // LAT=1, NREQ=3 instance
        u1_op(2, 32'h0000_0000, 32'h40A0_0000, 32'h0000_0000);
        u1_op(0, 32'h3F80_0000, 32'h40A0_0000, 32'h40A0_0000);
        u1_op(1, 32'h0000_0000, 32'h40A0_0000, 32'h0000_0000);

        // Randomised traffic with random response backpressure
        clear_logs();
        rr_mode = 2;
        base = 0;
        for (int n = 0; n < 30; n++) begin
            push(0, rand_fp(), rand_fp());
            push(1, rand_fp(), rand_fp());
        end
        wait_rsp(base + 60, "t7_timeout", ok);
        rr_mode = 0;
        repeat (4) @(posedge clk);
        chk("scoreboard_drained", 32'(exp_q[0].size() + exp_q[1].size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
